// File: rtl/csa_iter_mult8.sv
// -----------------------------------------------------------------------------
// csa_iter_mult8
// Iterative carry-save partial-product accumulator for an unsigned
// WIDTH x WIDTH multiply. One partial-product row is folded per clock into a
// redundant (sum, carry) pair through a 3:2 compressor. The final
// carry-propagate adder downstream resolves product = sum_vec + carry_vec
// (mod 2^(2*WIDTH)).
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   operands a/b valid           in_ready   block can accept operands
//   a, b       unsigned operands (WIDTH)
//   out_valid  sum_vec/carry_vec hold a completed result
//   out_ready  downstream adder consumes the result
//   sum_vec    redundant sum row (2*WIDTH)
//   carry_vec  redundant carry row, already weight-aligned (2*WIDTH)
//   busy       high while accumulating
// -----------------------------------------------------------------------------
module csa_iter_mult8 #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] sum_vec,
    output logic [2*WIDTH-1:0] carry_vec,
    output logic               busy
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e          state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [CW-1:0]   cnt_q;
    logic [PW-1:0]   s_q;
    logic [PW-1:0]   c_q;
    logic            in_ready_q;
    logic            out_valid_q;
    logic            busy_q;

    logic [PW-1:0]   row_s;
    logic [PW-1:0]   maj_s;
    logic [PW-1:0]   s_d;
    logic [PW-1:0]   c_d;

    // 3:2 compressor: fold the current partial-product row into (S, C).
    always_comb begin
        row_s = {PW{1'b0}};
        if (b_q[cnt_q]) begin
            row_s = {{WIDTH{1'b0}}, a_q} << cnt_q;
        end else begin
            row_s = {PW{1'b0}};
        end
        s_d   = s_q ^ c_q ^ row_s;
        maj_s = (s_q & c_q) | (s_q & row_s) | (c_q & row_s);
        // Carry moves up one weight; the bit leaving the MSB cannot be part of
        // a valid product (< 2^PW), so it is dropped.
        c_d   = {maj_s[PW-2:0], 1'b0};
    end

    // Control FSM, operand/accumulator registers and registered handshake flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            a_q         <= {WIDTH{1'b0}};
            b_q         <= {WIDTH{1'b0}};
            cnt_q       <= {CW{1'b0}};
            s_q         <= {PW{1'b0}};
            c_q         <= {PW{1'b0}};
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_q        <= a;
                        b_q        <= b;
                        cnt_q      <= {CW{1'b0}};
                        s_q        <= {PW{1'b0}};
                        c_q        <= {PW{1'b0}};
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    // Every row costs one cycle, zero or not, so latency is fixed.
                    s_q   <= s_d;
                    c_q   <= c_d;
                    cnt_q <= cnt_q + {{(CW-1){1'b0}}, 1'b1};
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // Result held until consumed; the next operand is taken
                    // no earlier than the edge after this handshake.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign sum_vec   = s_q;
    assign carry_vec = c_q;

endmodule

// File: tb/tb_csa_iter_mult8.sv
module tb_csa_iter_mult8;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a_s;
    logic [7:0]  b_s;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum_vec;
    logic [15:0] carry_vec;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int n_acc = 0;
    int n_out = 0;
    int n_abort = 0;
    logic [15:0] sb_q[$];

    csa_iter_mult8 #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a_s),
        .b         (b_s),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum_vec   (sum_vec),
        .carry_vec (carry_vec),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: push a*b at every accept, pop and compare at every result handshake.
    always @(posedge clk) begin
        if (rst) begin
            n_abort += sb_q.size();
            sb_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_out++;
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_result", 32'd1, 32'd0);
                end else begin
                    check("sb_product", 32'(16'(sum_vec + carry_vec)), 32'(sb_q.pop_front()));
                    check("sb_carry_lsb", 32'(carry_vec[0]), 32'd0);
                end
            end
            if (in_valid && in_ready) begin
                sb_q.push_back(16'(a_s) * 16'(b_s));
                n_acc++;
            end
        end
    end

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        int          hold;
        bit          probe;
        bit          zero;
        logic [15:0] prod;
    } vec_t;

    // One directed transaction: accept, latency, optional backpressure hold, handshake.
    task automatic run_op(input vec_t v);
        int n;
        int lat;
        logic [15:0] sv;
        logic [15:0] cv;
        n = 0;
        while (!in_ready && n < 50) begin step(); n++; end
        check("wait_in_ready_timeout", 32'(n < 50), 32'd1);
        in_valid = 1'b1; a_s = v.a; b_s = v.b; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        check("accum_busy", 32'(busy), 32'd1);
        check("accum_in_ready", 32'(in_ready), 32'd0);
        lat = 0;
        while (!out_valid && lat < 50) begin step(); lat++; end
        check("latency", 32'(lat), 32'd8);
        check("done_busy", 32'(busy), 32'd0);
        check("done_in_ready", 32'(in_ready), 32'd0);
        check("product", 32'(16'(sum_vec + carry_vec)), 32'(v.prod));
        check("carry_lsb", 32'(carry_vec[0]), 32'd0);
        if (v.zero) begin
            check("zero_sum", 32'(sum_vec), 32'd0);
            check("zero_carry", 32'(carry_vec), 32'd0);
        end
        sv = sum_vec; cv = carry_vec;
        for (int i = 0; i < v.hold; i++) begin
            if (v.probe) begin in_valid = 1'b1; a_s = 8'h01; b_s = 8'h01; end
            step();
            check("hold_sum", 32'(sum_vec), 32'(sv));
            check("hold_carry", 32'(carry_vec), 32'(cv));
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("post_hs_out_valid", 32'(out_valid), 32'd0);
        check("post_hs_in_ready", 32'(in_ready), 32'd1);
    endtask

    vec_t vecs[7];
    bit   sweep_done;

    initial begin
        vecs[0] = '{a: 8'hFF, b: 8'hFF, hold: 0, probe: 1'b0, zero: 1'b0, prod: 16'hFE01};
        vecs[1] = '{a: 8'h00, b: 8'hA5, hold: 0, probe: 1'b0, zero: 1'b1, prod: 16'h0000};
        vecs[2] = '{a: 8'h3C, b: 8'h00, hold: 0, probe: 1'b0, zero: 1'b1, prod: 16'h0000};
        vecs[3] = '{a: 8'h0D, b: 8'h0B, hold: 5, probe: 1'b1, zero: 1'b0, prod: 16'h008F};
        vecs[4] = '{a: 8'h01, b: 8'h01, hold: 1, probe: 1'b0, zero: 1'b0, prod: 16'h0001};
        vecs[5] = '{a: 8'hFF, b: 8'h01, hold: 0, probe: 1'b0, zero: 1'b0, prod: 16'h00FF};
        vecs[6] = '{a: 8'h80, b: 8'h80, hold: 2, probe: 1'b0, zero: 1'b0, prod: 16'h4000};

        rst = 1'b1; in_valid = 1'b0; a_s = 8'h00; b_s = 8'h00; out_ready = 1'b0;
        step(); step();
        rst = 1'b0;

        // Idle after reset.
        for (int i = 0; i < 20; i++) begin
            check("idle_in_ready", 32'(in_ready), 32'd1);
            check("idle_out_valid", 32'(out_valid), 32'd0);
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_sum", 32'(sum_vec), 32'd0);
            check("idle_carry", 32'(carry_vec), 32'd0);
            step();
        end

        for (int i = 0; i < 7; i++) run_op(vecs[i]);

        // Reset during accumulation cycle 4 discards the operation.
        in_valid = 1'b1; a_s = 8'h80; b_s = 8'h80;
        step();
        in_valid = 1'b0;
        step(); step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_sum", 32'(sum_vec), 32'd0);
        check("abort_carry", 32'(carry_vec), 32'd0);
        begin
            int seen;
            seen = 0;
            out_ready = 1'b1;
            for (int i = 0; i < 15; i++) begin
                if (out_valid) seen++;
                step();
            end
            out_ready = 1'b0;
            check("abort_no_result", 32'(seen), 32'd0);
        end
        run_op(vecs[6]);

        // Random back-to-back sweep with random backpressure.
        sweep_done = 1'b0;
        fork
            begin
                for (int k = 0; k < 3000; k++) begin
                    int n;
                    in_valid = 1'b1;
                    a_s = (k < 4) ? 8'(k * 85) : 8'($urandom);
                    b_s = (k < 4) ? 8'hFF - 8'(k * 85) : 8'($urandom);
                    n = 0;
                    while (!in_ready && n < 200) begin step(); n++; end
                    if (n >= 200) begin
                        check("sweep_accept_timeout", 32'd1, 32'd0);
                        break;
                    end
                    step();
                    in_valid = 1'b0;
                end
                sweep_done = 1'b1;
            end
            begin
                while (!sweep_done) begin
                    out_ready = 1'($urandom_range(0, 1));
                    step();
                end
            end
        join
        out_ready = 1'b1;
        begin
            int n;
            n = 0;
            while (sb_q.size() != 0 && n < 50) begin step(); n++; end
        end
        step();
        out_ready = 1'b0;
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        check("sb_count", 32'(n_out), 32'(n_acc - n_abort));
        check("abort_count", 32'(n_abort), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
